// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: MMIO page offsets,
// STATUS bit positions and the address-region classification.
package dmem_pkg;

    localparam logic [15:0] OFF_CYCLE  = 16'h0000;
    localparam logic [15:0] OFF_CMP    = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_LED    = 16'h000C;

    localparam int ST_MATCH  = 0;
    localparam int ST_IRQ_EN = 1;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_t;

endpackage

// File: rtl/dmem_responder_timer.sv
// Cycle timer with compare register, sticky MATCH flag (write-1-clear),
// IRQ enable and a registered timer interrupt level.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_cmp_i,
    input  logic        wr_status_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] cycle_o,
    output logic [31:0] cmp_o,
    output logic [31:0] status_o,
    output logic        irq_o
);

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;

    always_comb begin
        cycle_d  = cycle_q + 32'd1;
        cmp_d    = wr_cmp_i ? wdata_i : cmp_q;
        irq_en_d = wr_status_i ? wdata_i[ST_IRQ_EN] : irq_en_q;
        match_d  = match_q;
        if (wr_status_i && wdata_i[ST_MATCH]) begin
            match_d = 1'b0;
        end
        // A hit on the same edge as a clear must win, so it is applied last.
        if (cycle_q == cmp_q) begin
            match_d = 1'b1;
        end
        irq_d = match_q & irq_en_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q  <= '0;
            cmp_q    <= 32'hFFFF_FFFF;
            match_q  <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            cmp_q    <= cmp_d;
            match_q  <= match_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        status_o            = '0;
        status_o[ST_MATCH]  = match_q;
        status_o[ST_IRQ_EN] = irq_en_q;
    end

    assign cycle_o = cycle_q;
    assign cmp_o   = cmp_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: word RAM plus a four-register MMIO page, with
// combinational read data, edge-committed writes and a one-cycle bus error pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LED_W     = 16,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [31:0]      daddr,
    input  logic [31:0]      ddata_w,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [31:0]      ddata_r,
    output logic [LED_W-1:0] leds,
    output logic             irq_timer,
    output logic             bus_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

    // Requests are level-valid with an implicit always-ready: every cycle with
    // MemRead or MemWrite high is one accepted transfer, answered that cycle.
    region_t          region;
    logic [15:0]      off;
    logic [AW-1:0]    ram_idx;
    logic             req, err, wr_ok, rd_ok, wr_mmio;
    logic [31:0]      ram_q [DEPTH];
    logic [LED_W-1:0] leds_q, leds_d;
    logic             bus_err_q;
    logic [31:0]      cycle_w, cmp_w, status_w;

    assign off     = daddr[15:0];
    assign ram_idx = daddr[AW+1:2];

    always_comb begin
        region = REG_UNMAPPED;
        if ({1'b0, daddr} < RAM_BYTES) begin
            region = REG_RAM;
        end else if (daddr[31:16] == MMIO_BASE[31:16]) begin
            case (off)
                OFF_CYCLE, OFF_CMP, OFF_STATUS, OFF_LED: region = REG_MMIO;
                default: region = REG_UNMAPPED;
            endcase
        end
    end

    assign req     = MemRead | MemWrite;
    assign err     = req & ((daddr[1:0] != 2'b00) | (region == REG_UNMAPPED)
                            | (MemRead & MemWrite));
    assign wr_ok   = MemWrite & ~err;
    assign rd_ok   = MemRead & ~err;
    assign wr_mmio = wr_ok & (region == REG_MMIO);

    // RAM is not reset; gating with RESET_N drops a store caught by reset.
    always_ff @(posedge CLK) begin
        if (RESET_N && wr_ok && region == REG_RAM) begin
            ram_q[ram_idx] <= ddata_w;
        end
    end

    assign leds_d = (wr_mmio && off == OFF_LED) ? ddata_w[LED_W-1:0] : leds_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            leds_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            leds_q    <= leds_d;
            bus_err_q <= err;
        end
    end

    mmio_timer u_timer (
        .clk_i       (CLK),
        .rst_ni      (RESET_N),
        .wr_cmp_i    (wr_mmio && off == OFF_CMP),
        .wr_status_i (wr_mmio && off == OFF_STATUS),
        .wdata_i     (ddata_w),
        .cycle_o     (cycle_w),
        .cmp_o       (cmp_w),
        .status_o    (status_w),
        .irq_o       (irq_timer)
    );

    always_comb begin
        ddata_r = '0;
        if (rd_ok) begin
            case (region)
                REG_RAM: ddata_r = ram_q[ram_idx];
                REG_MMIO: begin
                    case (off)
                        OFF_CYCLE:  ddata_r = cycle_w;
                        OFF_CMP:    ddata_r = cmp_w;
                        OFF_STATUS: ddata_r = status_w;
                        OFF_LED:    ddata_r = 32'(leds_q);
                        default:    ddata_r = '0;
                    endcase
                end
                default: ddata_r = '0;
            endcase
        end
    end

    assign leds    = leds_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic, all checked
// against a behavioural model of the memory map, timer and error rules.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LED_W = 16;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_LED    = 32'hFFFF_000C;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [31:0]      daddr, ddata_w;
    logic             MemRead, MemWrite;
    logic [31:0]      ddata_r;
    logic [LED_W-1:0] leds;
    logic             irq_timer, bus_err;

    dmem_responder #(.DEPTH(DEPTH), .LED_W(LED_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
        .MemRead(MemRead), .MemWrite(MemWrite), .ddata_r(ddata_r),
        .leds(leds), .irq_timer(irq_timer), .bus_err(bus_err)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0]      ram_m [int];
    logic [31:0]      cycle_m, cmp_m;
    logic             match_m, irq_en_m, irq_m, err_m;
    logic [LED_W-1:0] led_m;

    function automatic int kind_of(input logic [31:0] a);
        if (a < 32'(DEPTH * 4)) return 0;
        if (a == A_CYCLE || a == A_CMP || a == A_STATUS || a == A_LED) return 1;
        return 2;
    endfunction

    function automatic logic is_err(input logic rd, input logic wr, input logic [31:0] a);
        return (rd || wr) && (a[1:0] != 2'b00 || kind_of(a) == 2 || (rd && wr));
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic wr, input logic [31:0] a);
        if (!rd || is_err(rd, wr, a)) return 32'h0;
        if (kind_of(a) == 0) return ram_m[int'(a[31:2])];
        if (a == A_CYCLE) return cycle_m;
        if (a == A_CMP) return cmp_m;
        if (a == A_STATUS) return {30'h0, irq_en_m, match_m};
        return 32'(led_m);
    endfunction

    task automatic model_reset();
        cycle_m = 32'h0; cmp_m = 32'hFFFF_FFFF;
        match_m = 1'b0; irq_en_m = 1'b0; irq_m = 1'b0; err_m = 1'b0; led_m = '0;
    endtask

    task automatic model_edge(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic e, wok, hit;
        e   = is_err(rd, wr, a);
        wok = wr && !e;
        hit = (cycle_m == cmp_m);
        irq_m = match_m && irq_en_m;
        if (wok && a == A_STATUS && d[0]) match_m = 1'b0;
        if (hit) match_m = 1'b1;
        if (wok) begin
            if (kind_of(a) == 0) ram_m[int'(a[31:2])] = d;
            else if (a == A_CMP) cmp_m = d;
            else if (a == A_STATUS) irq_en_m = d[1];
            else if (a == A_LED) led_m = d[LED_W-1:0];
        end
        cycle_m = cycle_m + 32'd1;
        err_m   = e;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead = rd; MemWrite = wr; daddr = a; ddata_w = d;
        #1;
        exp_q.push_back(model_read(rd, wr, a));
        obs_rd = ddata_r;
        check("ddata_r", ddata_r, exp_q.pop_front());
        check("leds", 32'(leds), 32'(led_m));
        check("irq_timer", 32'(irq_timer), 32'(irq_m));
        check("bus_err", 32'(bus_err), 32'(err_m));
        @(posedge CLK);
        model_edge(rd, wr, a, d);
        @(negedge CLK);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] d);
        MemRead = 1'b0; MemWrite = 1'b1; daddr = a; ddata_w = d;
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_irq", 32'(irq_timer), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        MemWrite = 1'b0;
        RESET_N = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d, saved;
        int k;
        RESET_N = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; daddr = '0; ddata_w = '0;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_irq", 32'(irq_timer), 32'h0);
        check("reset_bus_err", 32'(bus_err), 32'h0);
        MemRead = 1'b1; daddr = A_CMP; #1;
        check("reset_cmp", ddata_r, 32'hFFFF_FFFF);
        MemRead = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;

        // RAM and LED basics (cycles 0..3)
        do_cycle(0, 1, 32'h10, 32'hDEAD_BEEF);
        do_cycle(1, 0, 32'h10, 0);
        check("ram_load", obs_rd, 32'hDEAD_BEEF);
        check("ram_no_err", 32'(bus_err), 32'h0);
        do_cycle(0, 1, A_LED, 32'h1234_ABCD);
        do_cycle(1, 0, A_LED, 0);
        check("led_read", obs_rd, 32'h0000_ABCD);
        check("led_out", 32'(leds), 32'h0000_ABCD);
        // timer setup: CMP at cycle 5, IRQ_EN at cycle 6
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 1, A_CMP, 32'd20);
        do_cycle(0, 1, A_STATUS, 32'd2);
        do_cycle(1, 0, A_STATUS, 0);
        check("status_en", obs_rd, 32'h2);
        // error cases (cycles 8..13)
        do_cycle(0, 1, 32'h13, 32'h0000_0BAD);
        check("err_misaligned", 32'(bus_err), 32'h1);
        do_cycle(0, 1, 32'h8000_0000, 32'h0000_0BAD);
        check("err_unmapped", 32'(bus_err), 32'h1);
        do_cycle(1, 1, 32'h10, 32'h0);
        check("err_rdwr_data", obs_rd, 32'h0);
        check("err_rdwr", 32'(bus_err), 32'h1);
        do_cycle(1, 0, 32'h10, 0);
        check("ram_unchanged", obs_rd, 32'hDEAD_BEEF);
        check("err_pulse_end", 32'(bus_err), 32'h0);
        do_cycle(0, 0, 0, 0);
        do_cycle(1, 0, 32'h12, 0);
        check("misaligned_read", obs_rd, 32'h0);
        // cycles 14..19 read CYCLE
        for (int i = 0; i < 6; i++) do_cycle(1, 0, A_CYCLE, 0);
        check("cycle_19", obs_rd, 32'd19);
        do_cycle(1, 0, A_STATUS, 0);
        check("pre_match", obs_rd, 32'h2);
        check("irq_not_yet", 32'(irq_timer), 32'h0);
        do_cycle(1, 0, A_STATUS, 0);
        check("match_set", obs_rd, 32'h3);
        check("irq_high", 32'(irq_timer), 32'h1);
        do_cycle(0, 1, A_STATUS, 32'h3);
        check("irq_hold", 32'(irq_timer), 32'h1);
        do_cycle(1, 0, A_STATUS, 0);
        check("match_cleared", obs_rd, 32'h2);
        check("irq_drop", 32'(irq_timer), 32'h0);

        // set beats write-1-clear on the same edge
        do_cycle(0, 1, A_CMP, 32'd40);
        for (int i = 0; i < 100 && cycle_m != 32'd40; i++) do_cycle(0, 0, 0, 0);
        do_cycle(0, 1, A_STATUS, 32'h3);
        do_cycle(1, 0, A_STATUS, 0);
        check("set_wins", obs_rd, 32'h3);
        do_cycle(0, 1, A_STATUS, 32'h1);
        do_cycle(1, 0, A_STATUS, 0);
        check("status_off", obs_rd, 32'h0);
        do_cycle(0, 1, A_CYCLE, 32'h0);
        do_cycle(1, 0, A_CYCLE, 0);
        check("cycle_ro", obs_rd, cycle_m - 32'd1);
        check("cycle_ro_noerr", 32'(bus_err), 32'h0);
        // RAM top boundary
        do_cycle(0, 1, 32'h0000_0FFC, 32'h5555_AAAA);
        do_cycle(1, 0, 32'h0000_0FFC, 0);
        check("ram_top", obs_rd, 32'h5555_AAAA);
        do_cycle(1, 0, 32'h0000_1000, 0);
        check("ram_past_top", obs_rd, 32'h0);
        check("ram_past_top_err", 32'(bus_err), 32'h1);

        // random traffic
        for (int i = 0; i < 16; i++) do_cycle(0, 1, 32'(i * 4), $urandom);
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            d = $urandom;
            case (k)
                0, 1, 2, 3: a = 32'($urandom_range(0, 15) * 4);
                4: a = 32'hFFFF_0000 | 32'($urandom_range(0, 3) * 4);
                5: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                6: a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_0010 : 32'h8000_0000 | 32'($urandom_range(0, 255) * 4);
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            if (k == 7) do_cycle(1, 1, a, d);
            else if (k == 8) do_cycle(0, 0, a, d);
            else if (k == 9) do_cycle(0, 1, A_CMP, cycle_m + 32'($urandom_range(1, 10)));
            else if ($urandom_range(0, 1) == 0) do_cycle(1, 0, a, d);
            else do_cycle(0, 1, a, d);
        end

        // counter wrap with CMP=0
        do_cycle(0, 1, A_CMP, 32'h0);
        do_cycle(0, 1, A_STATUS, 32'h3);
        do_cycle(1, 0, A_STATUS, 0);
        check("wrap_prep", obs_rd, 32'h2);
        force dut.u_timer.cycle_q = 32'hFFFF_FFFD;
        #1;
        release dut.u_timer.cycle_q;
        cycle_m = 32'hFFFF_FFFD;
        do_cycle(1, 0, A_CYCLE, 0);
        check("wrap_fd", obs_rd, 32'hFFFF_FFFD);
        do_cycle(1, 0, A_CYCLE, 0);
        do_cycle(1, 0, A_CYCLE, 0);
        check("wrap_ff", obs_rd, 32'hFFFF_FFFF);
        do_cycle(1, 0, A_CYCLE, 0);
        check("wrap_zero", obs_rd, 32'h0);
        do_cycle(1, 0, A_STATUS, 0);
        check("wrap_match", obs_rd, 32'h3);
        check("wrap_irq", 32'(irq_timer), 32'h1);

        // asynchronous reset during a store
        do_cycle(0, 1, A_LED, 32'h5A5A);
        do_cycle(0, 1, 32'h13, 32'h0);
        check("pre_rst_err", 32'(bus_err), 32'h1);
        reset_mid_store(A_LED, 32'h0000_FFFF);
        do_cycle(1, 0, A_LED, 0);
        check("led_lost", obs_rd, 32'h0);
        saved = ram_m[4];
        reset_mid_store(32'h10, 32'h0BAD_F00D);
        do_cycle(1, 0, 32'h10, 0);
        check("ram_store_lost", obs_rd, saved);
        do_cycle(1, 0, A_CMP, 0);
        check("cmp_after_rst", obs_rd, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
